// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        RELEASE,
        RUN,
        SW_HOLD
    } seq_state_t;

    localparam int LOCK_CNT_W = 8;
    localparam logic [LOCK_CNT_W-1:0] LOCK_CNT_MAX = '1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/two_ff_sync.sv
// 1-bit two-stage synchroniser with asynchronous active-high clear to 0.
module two_ff_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Lock-qualified, ordered release of per-domain active-low reset requests.
// Build option: define RESET_SEQ_LOCK_CNT_EN to enable the saturating lock-loss counter.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS        = 3,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY        = 16,
    parameter int SW_HOLD_CYCLES     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] rst_n_out,
    output logic                   seq_done,
    output logic                   sw_rst_ack,
    output logic [LOCK_CNT_W-1:0]  lock_loss_cnt
);

    localparam int CYC_MAX = max3(LOCK_STABLE_CYCLES, STAGE_DELAY, SW_HOLD_CYCLES);
    localparam int CYC_W   = $clog2(CYC_MAX) + 1;
    localparam int IDX_W   = $clog2(NUM_DOMAINS) + 1;

    localparam logic [CYC_W-1:0] LOCK_LAST  = CYC_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] STAGE_LAST = CYC_W'(STAGE_DELAY - 1);
    localparam logic [CYC_W-1:0] HOLD_LAST  = CYC_W'(SW_HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DOMAINS - 1);

    seq_state_t             r_state;
    seq_state_t             w_state_next;
    logic [CYC_W-1:0]       r_cyc;
    logic [CYC_W-1:0]       w_cyc_next;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_next;
    logic [NUM_DOMAINS-1:0] r_rst_n;
    logic [NUM_DOMAINS-1:0] w_rst_n_next;
    logic                   r_done;
    logic                   w_done_next;
    logic                   r_ack;
    logic                   w_ack_next;

    logic                   w_lock_s;
    logic                   w_lock_loss;
    logic [NUM_DOMAINS-1:0] w_rel_mask;

    two_ff_sync u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (pll_locked),
        .o_q (w_lock_s)
    );

    // Lock loss anywhere past WAIT_LOCK pre-empts every other transition.
    assign w_lock_loss = !w_lock_s && (r_state != WAIT_LOCK);

    generate
        for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_rel_mask
            assign w_rel_mask[gi] = (r_idx == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_cyc_next   = r_cyc;
        w_idx_next   = r_idx;
        w_rst_n_next = r_rst_n;
        w_done_next  = r_done;
        w_ack_next   = 1'b0;

        if (w_lock_loss) begin
            w_state_next = WAIT_LOCK;
            w_cyc_next   = '0;
            w_idx_next   = '0;
            w_rst_n_next = '0;
            w_done_next  = 1'b0;
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    w_rst_n_next = '0;
                    w_done_next  = 1'b0;
                    if (!w_lock_s) begin
                        w_cyc_next = '0;
                    end else if (r_cyc == LOCK_LAST) begin
                        w_state_next = RELEASE;
                        w_cyc_next   = '0;
                        w_idx_next   = '0;
                    end else begin
                        w_cyc_next = r_cyc + CYC_W'(1);
                    end
                end
                RELEASE: begin
                    if (r_cyc == STAGE_LAST) begin
                        w_rst_n_next = r_rst_n | w_rel_mask;
                        w_idx_next   = r_idx + IDX_W'(1);
                        w_cyc_next   = '0;
                        if (r_idx == IDX_LAST) begin
                            w_state_next = RUN;
                            w_done_next  = 1'b1;
                        end
                    end else begin
                        w_cyc_next = r_cyc + CYC_W'(1);
                    end
                end
                RUN: begin
                    if (sw_rst_req) begin
                        w_state_next = SW_HOLD;
                        w_rst_n_next = '0;
                        w_done_next  = 1'b0;
                        w_ack_next   = 1'b1;
                        w_cyc_next   = '0;
                    end
                end
                SW_HOLD: begin
                    // Lock was already proven stable, so go straight back to releasing.
                    if (r_cyc == HOLD_LAST) begin
                        w_state_next = RELEASE;
                        w_cyc_next   = '0;
                        w_idx_next   = '0;
                    end else begin
                        w_cyc_next = r_cyc + CYC_W'(1);
                    end
                end
                default: begin
                    w_state_next = WAIT_LOCK;
                    w_cyc_next   = '0;
                    w_idx_next   = '0;
                    w_rst_n_next = '0;
                    w_done_next  = 1'b0;
                end
            endcase
        end
    end

`ifdef RESET_SEQ_LOCK_CNT_EN
    logic [LOCK_CNT_W-1:0] r_lock_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT_LOCK;
            r_cyc   <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_done  <= 1'b0;
            r_ack   <= 1'b0;
`ifdef RESET_SEQ_LOCK_CNT_EN
            r_lock_cnt <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cyc   <= w_cyc_next;
            r_idx   <= w_idx_next;
            r_rst_n <= w_rst_n_next;
            r_done  <= w_done_next;
            r_ack   <= w_ack_next;
`ifdef RESET_SEQ_LOCK_CNT_EN
            if (w_lock_loss && (r_lock_cnt != LOCK_CNT_MAX)) begin
                r_lock_cnt <= r_lock_cnt + LOCK_CNT_W'(1);
            end
`endif
        end
    end

    assign rst_n_out  = r_rst_n;
    assign seq_done   = r_done;
    assign sw_rst_ack = r_ack;

`ifdef RESET_SEQ_LOCK_CNT_EN
    assign lock_loss_cnt = r_lock_cnt;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule
